sm83_cb_exec: RTL and testbench
===============================

SM83_CB_EXEC -- requirements
Module: sm83_cb_exec

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports: clk  in  1  rising-edge clock; rst_n  in  1  async active-low reset.
REQ-002 start  in  1  sampled only in IDLE; launches the CB-prefixed op in opcode.
REQ-003 opcode  in  8  CB second byte, valid with start; [7:6] group, [5:3] sub-op/bit index, [2:0] target (0 B, 1 C, 2 D, 3 E, 4 H, 5 L, 6 (HL), 7 A).
REQ-004 busy  out  1  high in every non-IDLE state.
REQ-005 done  out  1  one-cycle completion pulse.
REQ-006 rf_rd_sel  out  3  register-file read select; rf_rd_data  in  r8_t  combinational read data.
REQ-007 rf_wr_en  out  1, rf_wr_sel  out  3, rf_wr_data  out  r8_t  register write-back port.
REQ-008 hl  in  16  current HL pair, used as the (HL) address.
REQ-009 mem_addr  out  16, mem_rd  out  1, mem_wr  out  1, mem_wdata  out  r8_t, mem_rdata  in  r8_t, mem_ack  in  1  memory request/acknowledge port.
REQ-010 alu_op  out  alu_op_t, alu_op1  out  r8_t, alu_op2  out  r8_t, alu_flags_in  out  flags_t  drive the shared 8-bit ALU.
REQ-011 alu_result  in  r8_t, alu_flags_out  in  flags_t  ALU combinational response.
REQ-012 flags_in  in  flags_t  current F; flags_wr_en  out  1, flags_out  out  flags_t  F write-back.

Function
REQ-013 States SHALL be IDLE, MEM_RD, EXEC, MEM_WR; opcode latched on the start cycle.
REQ-014 IDLE + start, target != 6 -> EXEC; target == 6 -> MEM_RD.
REQ-015 MEM_RD: mem_rd=1, mem_addr=hl until the cycle mem_ack=1; mem_rdata captured into an operand register on that edge; -> EXEC.
REQ-016 EXEC lasts exactly one cycle; alu_op1 = operand (rf_rd_data with rf_rd_sel=target, or captured byte), alu_op2 = 0, alu_flags_in = flags_in.
REQ-017 Group 00 SHALL map [5:3] 0..7 to ALU_RLC, ALU_RRC, ALU_RL, ALU_RR, ALU_SLA, ALU_SRA, ALU_SWAP, ALU_SRL; group 01/10/11 to ALU_BIT_n/ALU_RES_n/ALU_SET_n with n=[5:3].
REQ-018 alu_op SHALL be ALU_NOP in every state other than EXEC.
REQ-019 Group 00 flags: Z=alu_flags_out.z, N=0, H=0, C=alu_flags_out.c; SWAP forces C=0.
REQ-020 BIT flags: Z=alu_flags_out.z, N=0, H=1, C=flags_in.c; RES/SET write no flags (flags_wr_en=0).
REQ-021 flags_wr_en SHALL pulse only in EXEC, for groups 00 and 01.
REQ-022 Register target: EXEC asserts rf_wr_en (except BIT), rf_wr_sel=target, rf_wr_data=alu_result, done=1; -> IDLE. Latency start->done = 1 cycle.
REQ-023 (HL) target, BIT: EXEC asserts done, -> IDLE; no memory write.
REQ-024 (HL) target, others: EXEC latches alu_result into mem_wdata; -> MEM_WR; mem_wr=1, mem_addr=hl until mem_ack=1; done on the ack cycle; -> IDLE.
REQ-025 mem_rd and mem_wr SHALL never be high together; rf_wr_en never high for (HL) targets.
REQ-026 start while busy SHALL be ignored; mem_ack outside MEM_RD/MEM_WR ignored.
REQ-027 mem_ack SHALL be accepted in the first cycle of MEM_RD/MEM_WR (zero-wait); no timeout.

Reset
REQ-028 rst_n low SHALL, asynchronously and mid-operation, force IDLE and drive busy, done, rf_wr_en, flags_wr_en, mem_rd, mem_wr = 0, alu_op = ALU_NOP, mem_addr, mem_wdata, rf_wr_data, flags_out, latched opcode/operand = 0.
REQ-029 After rst_n rises, the first start SHALL be honoured on the next clock edge.

Verification
REQ-030 opcode 8'h37 (SWAP A), A=8'hF0, F.C=1 -> next cycle: rf_wr_en, sel 7, data 8'h0F, flags Z0 N0 H0 C0, done.
REQ-031 opcode 8'h10 (RL B), B=8'h80, F.C=0 -> B=8'h00, flags Z1 N0 H0 C1, latency 1.
REQ-032 opcode 8'h7E (BIT 7,(HL)), hl=16'hC000, mem_rdata=8'h7F, ack after 3 cycles -> flags Z1 N0 H1 C unchanged, no mem_wr, no rf_wr_en, done once.
REQ-033 opcode 8'hC6 (SET 0,(HL)), mem_rdata=8'h10 -> mem_wr with wdata 8'h11 at 16'hC000 held until ack, flags_wr_en never high.
REQ-034 rst_n pulsed low during MEM_WR -> mem_wr drops immediately, busy 0, no done; new start afterwards completes normally.
REQ-035 start re-asserted during MEM_RD with a different opcode -> ignored; original op completes with original result.

Source files
------------

// File: rtl/sm83_cb_exec.sv
// SM83 CB-prefix executor: rotates/shifts, BIT/RES/SET on a register or (HL),
// using an external 8-bit ALU. Flags pack as {z, n, h, c}.
module sm83_cb_exec (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  opcode,
  output logic        busy,
  output logic        done,
  output logic [2:0]  rf_rd_sel,
  input  logic [7:0]  rf_rd_data,
  output logic        rf_wr_en,
  output logic [2:0]  rf_wr_sel,
  output logic [7:0]  rf_wr_data,
  input  logic [15:0] hl,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [5:0]  alu_op,
  output logic [7:0]  alu_op1,
  output logic [7:0]  alu_op2,
  output logic [3:0]  alu_flags_in,
  input  logic [7:0]  alu_result,
  input  logic [3:0]  alu_flags_out,
  input  logic [3:0]  flags_in,
  output logic        flags_wr_en,
  output logic [3:0]  flags_out
);

  // ALU op codes: rotate/shift group at 1..8, BIT/RES/SET at base + bit index.
  localparam logic [5:0] ALU_NOP  = 6'd0;
  localparam logic [5:0] ALU_RLC  = 6'd1;
  localparam logic [5:0] ALU_BIT0 = 6'd16;
  localparam logic [5:0] ALU_RES0 = 6'd24;
  localparam logic [5:0] ALU_SET0 = 6'd32;

  typedef enum logic [1:0] {S_IDLE, S_MEM_RD, S_EXEC, S_MEM_WR} state_t;

  state_t     state, state_nx;
  logic [7:0] op_q, operand_q, wdata_q;
  logic [1:0] grp;
  logic [2:0] sub, tgt;
  logic       is_mem, is_bit;
  logic       unused_alu_nh;

  assign grp    = op_q[7:6];
  assign sub    = op_q[5:3];
  assign tgt    = op_q[2:0];
  assign is_mem = (tgt == 3'd6);
  assign is_bit = (grp == 2'b01);

  assign unused_alu_nh = ^alu_flags_out[2:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_q      <= '0;
      operand_q <= '0;
      wdata_q   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && start)
        op_q <= opcode;
      if (state == S_MEM_RD && mem_ack)
        operand_q <= mem_rdata;
      if (state == S_EXEC && is_mem && !is_bit)
        wdata_q <= alu_result;
    end
  end

  always_comb begin
    state_nx     = state;
    busy         = (state != S_IDLE);
    done         = 1'b0;
    rf_rd_sel    = tgt;
    rf_wr_en     = 1'b0;
    rf_wr_sel    = '0;
    rf_wr_data   = '0;
    mem_addr     = '0;
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_wdata    = wdata_q;
    alu_op       = ALU_NOP;
    alu_op1      = '0;
    alu_op2      = '0;
    alu_flags_in = '0;
    flags_wr_en  = 1'b0;
    flags_out    = '0;

    case (state)
      S_IDLE: begin
        if (start)
          state_nx = (opcode[2:0] == 3'd6) ? S_MEM_RD : S_EXEC;
      end

      S_MEM_RD: begin
        mem_rd   = 1'b1;
        mem_addr = hl;
        if (mem_ack)
          state_nx = S_EXEC;
      end

      S_EXEC: begin
        case (grp)
          2'b00:   alu_op = ALU_RLC + {3'b000, sub};
          2'b01:   alu_op = ALU_BIT0 + {3'b000, sub};
          2'b10:   alu_op = ALU_RES0 + {3'b000, sub};
          default: alu_op = ALU_SET0 + {3'b000, sub};
        endcase
        alu_op1      = is_mem ? operand_q : rf_rd_data;
        alu_flags_in = flags_in;

        if (grp == 2'b00) begin
          flags_wr_en = 1'b1;
          // SWAP never carries, whatever the ALU reports.
          flags_out   = {alu_flags_out[3], 2'b00,
                         (sub == 3'd6) ? 1'b0 : alu_flags_out[0]};
        end else if (is_bit) begin
          flags_wr_en = 1'b1;
          flags_out   = {alu_flags_out[3], 1'b0, 1'b1, flags_in[0]};
        end

        if (!is_mem) begin
          if (!is_bit) begin
            rf_wr_en   = 1'b1;
            rf_wr_sel  = tgt;
            rf_wr_data = alu_result;
          end
          done     = 1'b1;
          state_nx = S_IDLE;
        end else if (is_bit) begin
          done     = 1'b1;
          state_nx = S_IDLE;
        end else begin
          state_nx = S_MEM_WR;
        end
      end

      S_MEM_WR: begin
        mem_wr   = 1'b1;
        mem_addr = hl;
        if (mem_ack) begin
          done     = 1'b1;
          state_nx = S_IDLE;
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sm83_cb_exec.sv
// Scoreboard bench for sm83_cb_exec: directed CB ops, a behavioural ALU,
// register file and memory with programmable ack delay.
module tb_sm83_cb_exec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  opcode = '0;
  logic        busy, done;
  logic [2:0]  rf_rd_sel, rf_wr_sel;
  logic [7:0]  rf_rd_data, rf_wr_data;
  logic        rf_wr_en;
  logic [15:0] hl = 16'hC000;
  logic [15:0] mem_addr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [5:0]  alu_op;
  logic [7:0]  alu_op1, alu_op2, alu_result;
  logic [3:0]  alu_flags_in, alu_flags_out;
  logic [3:0]  flags_in = '0;
  logic        flags_wr_en;
  logic [3:0]  flags_out;

  always #5 clk = ~clk;

  sm83_cb_exec dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .busy(busy), .done(done),
    .rf_rd_sel(rf_rd_sel), .rf_rd_data(rf_rd_data),
    .rf_wr_en(rf_wr_en), .rf_wr_sel(rf_wr_sel), .rf_wr_data(rf_wr_data),
    .hl(hl), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_op(alu_op), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_flags_in(alu_flags_in), .alu_result(alu_result),
    .alu_flags_out(alu_flags_out),
    .flags_in(flags_in), .flags_wr_en(flags_wr_en), .flags_out(flags_out)
  );

  // Register file: B C D E H L (HL) A
  logic [7:0] regs [8];
  initial begin
    regs[0] = 8'h80; regs[1] = 8'h81; regs[2] = 8'h01; regs[3] = 8'hFF;
    regs[4] = 8'hC0; regs[5] = 8'h00; regs[6] = 8'h00; regs[7] = 8'hF0;
  end
  assign rf_rd_data = regs[rf_rd_sel];

  // ALU reports N=H=1 and SWAP carry=1 so the executor's flag shaping is visible.
  function automatic logic [11:0] alu_model(input logic [5:0] op,
                                            input logic [7:0] a,
                                            input logic cin);
    logic [7:0] r;
    logic       c, z;
    int unsigned n;
    r = a;
    c = cin;
    n = int'(op[2:0]);
    case (op)
      6'd1: begin r = {a[6:0], a[7]}; c = a[7]; end
      6'd2: begin r = {a[0], a[7:1]}; c = a[0]; end
      6'd3: begin r = {a[6:0], cin};  c = a[7]; end
      6'd4: begin r = {cin, a[7:1]};  c = a[0]; end
      6'd5: begin r = {a[6:0], 1'b0}; c = a[7]; end
      6'd6: begin r = {a[7], a[7:1]}; c = a[0]; end
      6'd7: begin r = {a[3:0], a[7:4]}; c = 1'b1; end
      6'd8: begin r = {1'b0, a[7:1]}; c = a[0]; end
      default: begin
        if (op >= 6'd24 && op < 6'd32)      r = a & ~(8'd1 << n);
        else if (op >= 6'd32 && op < 6'd40) r = a | (8'd1 << n);
      end
    endcase
    z = (r == 8'h00);
    if (op >= 6'd16 && op < 6'd24) z = ~a[n];
    return {z, 1'b1, 1'b1, c, r};
  endfunction

  always_comb {alu_flags_out, alu_result} = alu_model(alu_op, alu_op1, alu_flags_in[0]);

  // Memory: ack arrives ack_delay cycles into each request.
  int unsigned ack_delay = 0;
  int unsigned wcnt = 0;
  always @(negedge clk) begin
    if (mem_rd || mem_wr) begin
      mem_ack = (wcnt == ack_delay);
      wcnt++;
    end else begin
      mem_ack = 1'b0;
      wcnt = 0;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       rf_we;
    logic [2:0] rf_sel;
    logic [7:0] rf_data;
    logic       fwe;
    logic [3:0] flags;
    logic       mw;
    logic [7:0] wdata;
  } exp_t;

  exp_t sb_q[$];

  // Monitor: accumulate what the DUT does during an op, judge it on done.
  int         seen_rfwe, seen_fwe, seen_mwack, viol;
  logic       mw_any;
  logic [2:0] s_sel;
  logic [7:0] s_rdata, s_wdata;
  logic [3:0] s_flags;
  logic [15:0] s_addr;

  task automatic clear_seen();
    seen_rfwe = 0; seen_fwe = 0; seen_mwack = 0; mw_any = 1'b0;
    s_sel = '0; s_rdata = '0; s_wdata = '0; s_flags = '0; s_addr = '0;
  endtask

  initial begin
    viol = 0;
    clear_seen();
  end

  always begin
    @(negedge clk);
    #2;
    if (!rst_n) begin
      clear_seen();
    end else begin
      if (mem_rd && mem_wr) viol++;
      if (rf_wr_en && rf_wr_sel == 3'd6) viol++;
      if ((mem_rd || mem_wr) && mem_addr !== hl) viol++;
      if ((mem_rd || mem_wr) && alu_op != 6'd0) viol++;
      if (!busy && (alu_op != 6'd0 || done || rf_wr_en || flags_wr_en || mem_rd || mem_wr)) viol++;
      if (rf_wr_en) begin seen_rfwe++; s_sel = rf_wr_sel; s_rdata = rf_wr_data; end
      if (flags_wr_en) begin seen_fwe++; s_flags = flags_out; end
      if (mem_wr) mw_any = 1'b1;
      if (mem_wr && mem_ack) begin seen_mwack++; s_wdata = mem_wdata; s_addr = mem_addr; end
      if (done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("rf_wr_count", seen_rfwe, e.rf_we);
          if (e.rf_we) begin
            check("rf_wr_sel", s_sel, e.rf_sel);
            check("rf_wr_data", s_rdata, e.rf_data);
          end
          check("flags_wr_count", seen_fwe, e.fwe);
          if (e.fwe) check("flags_out", s_flags, e.flags);
          check("mem_wr_seen", mw_any, e.mw);
          if (e.mw) begin
            check("mem_wr_acks", seen_mwack, 1);
            check("mem_wdata", s_wdata, e.wdata);
            check("mem_wr_addr", s_addr, 16'hC000);
          end
        end
        clear_seen();
      end
    end
  end

  task automatic run_op(input logic [7:0] op, input exp_t e, input int exp_lat,
                        input logic intrude);
    int cycles;
    @(negedge clk);
    opcode = op;
    start  = 1'b1;
    sb_q.push_back(e);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (intrude) begin
        if (cycles == 1) opcode = 8'h37;
        if (cycles == 3) start = 1'b0;
      end else begin
        start = 1'b0;
      end
      #2;
    end while (!done && cycles < 100);
    start  = 1'b0;
    opcode = '0;
    check("done_seen", done, 1);
    check("latency", cycles, exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_rd_wr", {mem_rd, mem_wr}, 0);
    check("rst_wr_enables", {rf_wr_en, flags_wr_en}, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_rf_wr_data", rf_wr_data, 0);
    check("rst_flags_out", flags_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    flags_in = 4'b0001;
    run_op(8'h37, '{1'b1, 3'd7, 8'h0F, 1'b1, 4'b0000, 1'b0, 8'h00}, 1, 1'b0);
    flags_in = 4'b0000;
    run_op(8'h10, '{1'b1, 3'd0, 8'h00, 1'b1, 4'b1001, 1'b0, 8'h00}, 1, 1'b0);

    flags_in = 4'b0001; mem_rdata = 8'h7F; ack_delay = 3;
    run_op(8'h7E, '{1'b0, 3'd0, 8'h00, 1'b1, 4'b1011, 1'b0, 8'h00}, 5, 1'b0);

    mem_rdata = 8'h10; ack_delay = 1;
    run_op(8'hC6, '{1'b0, 3'd0, 8'h00, 1'b0, 4'b0000, 1'b1, 8'h11}, 5, 1'b0);

    flags_in = 4'b0000; mem_rdata = 8'h85; ack_delay = 0;
    run_op(8'h06, '{1'b0, 3'd0, 8'h00, 1'b1, 4'b0001, 1'b1, 8'h0B}, 3, 1'b0);

    run_op(8'h29, '{1'b1, 3'd1, 8'hC0, 1'b1, 4'b0001, 1'b0, 8'h00}, 1, 1'b0);
    run_op(8'h47, '{1'b0, 3'd0, 8'h00, 1'b1, 4'b1010, 1'b0, 8'h00}, 1, 1'b0);
    run_op(8'h9B, '{1'b1, 3'd3, 8'hF7, 1'b0, 4'b0000, 1'b0, 8'h00}, 1, 1'b0);
    run_op(8'h3A, '{1'b1, 3'd2, 8'h00, 1'b1, 4'b1001, 1'b0, 8'h00}, 1, 1'b0);
    flags_in = 4'b0001;
    run_op(8'h0D, '{1'b1, 3'd5, 8'h00, 1'b1, 4'b1000, 1'b0, 8'h00}, 1, 1'b0);

    // A second start during MEM_RD must not disturb the op in flight.
    flags_in = 4'b0000; mem_rdata = 8'h85; ack_delay = 4;
    run_op(8'h06, '{1'b0, 3'd0, 8'h00, 1'b1, 4'b0001, 1'b1, 8'h0B}, 11, 1'b1);
    @(negedge clk);
    #2;
    check("idle_after_intrude", busy, 0);

    // Asynchronous reset while the write is outstanding.
    mem_rdata = 8'h10; ack_delay = 20;
    @(negedge clk);
    opcode = 8'hC6;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 50 && !mem_wr; i++) @(negedge clk);
    #2;
    check("reached_mem_wr", mem_wr, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem_wr", mem_wr, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_mem_wdata", mem_wdata, 0);
    check("rst_mid_mem_addr", mem_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    flags_in = 4'b0001;
    run_op(8'h37, '{1'b1, 3'd7, 8'h0F, 1'b1, 4'b0000, 1'b0, 8'h00}, 1, 1'b0);

    repeat (3) @(negedge clk);
    #3;
    check("scoreboard_empty", sb_q.size(), 0);
    check("protocol_violations", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
